prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_if.sv | 26 ++
 rtl/prog_loader_timer.sv | 29 ++
 rtl/prog_loader.sv | 119 +++++++++++
 tb/tb_prog_loader.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the serial program loader.
// Address width follows the default program memory depth.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        RUN,
        ERR
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         DEPTH_DEFAULT  = 16;
    localparam int         ADDR_W         = $clog2(DEPTH_DEFAULT);

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, program memory writes and CPU control out.
// The loader sits on the slave side of this interface.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
    );

endinterface

// File: rtl/prog_loader_timer.sv
// Idle-cycle watchdog for an in-progress frame.
// expired fires during the TIMEOUT-th consecutive idle cycle.
module loader_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Frame loader: HEADER, length, data bytes, 8-bit additive checksum.
// Holds the CPU in reset until a frame has been written and verified.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] HEADER  = HEADER_DEFAULT,
    parameter int         DEPTH   = DEPTH_DEFAULT,
    parameter int         TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus
);

    localparam int         LEN_W   = $clog2(DEPTH + 1);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t           state;
    state_t           next_state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] index;
    logic [7:0]       checksum;
    logic             accept;
    logic             len_ok;
    logic             last_byte;
    logic             in_frame;
    logic             expired;

    assign accept    = bus.in_valid && bus.in_ready;
    assign len_ok    = (bus.in_data != 8'd0) && (bus.in_data <= DEPTH_B);
    assign last_byte = ((index + 1'b1) == len);
    assign in_frame  = (state == LEN) || (state == DATA) || (state == CSUM);

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .enable  (in_frame),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Inside DATA a HEADER byte is ordinary payload, so only the idle states resync.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, RUN, ERR: begin
                if (accept && bus.in_data == HEADER) next_state = LEN;
            end
            LEN: begin
                if (accept)       next_state = len_ok ? DATA : ERR;
                else if (expired) next_state = ERR;
            end
            DATA: begin
                if (accept) begin
                    if (last_byte) next_state = CSUM;
                end else if (expired) begin
                    next_state = ERR;
                end
            end
            CSUM: begin
                if (accept)       next_state = (bus.in_data == checksum) ? RUN : ERR;
                else if (expired) next_state = ERR;
            end
            default: next_state = IDLE;
        endcase
    end

    // Status flags track the state being entered so they change with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_hold  <= 1'b1;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            len           <= '0;
            index         <= '0;
            checksum      <= '0;
        end else begin
            bus.in_ready <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.cpu_hold <= (next_state != RUN);
            bus.done     <= (next_state == RUN);
            bus.error    <= (next_state == ERR);
            case (state)
                LEN: begin
                    if (accept && len_ok) begin
                        len      <= bus.in_data[LEN_W-1:0];
                        index    <= '0;
                        checksum <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= index[ADDR_W-1:0];
                        bus.mem_wdata <= bus.in_data;
                        checksum      <= checksum + bus.in_data;
                        index         <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames, bad checksum, bad length,
// timeout, reload from RUN and reset in the middle of a frame.
module tb_prog_loader;

    logic clk = 1'b0;
    logic reset;
    int   total    = 0;
    int   bad      = 0;
    int   we_count = 0;
    int   w0;
    logic [7:0] sum;

    prog_loader_if bus();

    prog_loader #(
        .HEADER  (8'hA5),
        .DEPTH   (16),
        .TIMEOUT (255)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Counts write strobes mid-cycle, away from the edge that launches them.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) we_count <= we_count + 1;
    end

    task automatic applyStimulus(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkWrite(input string tag, input logic [3:0] addr, input logic [7:0] data);
        checkOutput({tag, "_we"}, 32'(bus.mem_we), 32'd1);
        checkOutput({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
        checkOutput({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(data));
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #2;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_error", 32'(bus.error), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        checkOutput("ready_after_reset", 32'(bus.in_ready), 32'd1);

        $display("[TB] valid frame");
        applyStimulus(8'hA5);
        checkOutput("v_hold_len", 32'(bus.cpu_hold), 32'd1);
        applyStimulus(8'h03);
        checkOutput("v_len_no_we", 32'(bus.mem_we), 32'd0);
        applyStimulus(8'h11);
        checkWrite("v_w0", 4'd0, 8'h11);
        applyStimulus(8'h22);
        checkWrite("v_w1", 4'd1, 8'h22);
        applyStimulus(8'h33);
        checkWrite("v_w2", 4'd2, 8'h33);
        checkOutput("v_hold_mid", 32'(bus.cpu_hold), 32'd1);
        applyStimulus(8'h66);
        checkOutput("v_csum_no_we", 32'(bus.mem_we), 32'd0);
        checkOutput("v_addr_hold", 32'(bus.mem_addr), 32'd2);
        checkOutput("v_wdata_hold", 32'(bus.mem_wdata), 32'h33);
        checkOutput("v_done", 32'(bus.done), 32'd1);
        checkOutput("v_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        checkOutput("v_error", 32'(bus.error), 32'd0);

        $display("[TB] reload from RUN with header byte as data");
        applyStimulus(8'h5A);
        checkOutput("run_ignores_junk", 32'(bus.done), 32'd1);
        applyStimulus(8'hA5);
        checkOutput("r_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("r_done", 32'(bus.done), 32'd0);
        applyStimulus(8'h02);
        applyStimulus(8'hA5);
        checkWrite("r_w0_header_data", 4'd0, 8'hA5);
        applyStimulus(8'h01);
        checkWrite("r_w1", 4'd1, 8'h01);
        applyStimulus(8'hA6);
        checkOutput("r_done_after", 32'(bus.done), 32'd1);
        checkOutput("r_hold_after", 32'(bus.cpu_hold), 32'd0);

        $display("[TB] bad checksum");
        w0 = we_count;
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h10);
        checkWrite("b_w0", 4'd0, 8'h10);
        applyStimulus(8'h20);
        checkWrite("b_w1", 4'd1, 8'h20);
        applyStimulus(8'h31);
        idle(1);
        checkOutput("b_we_count", 32'(we_count - w0), 32'd2);
        checkOutput("b_error", 32'(bus.error), 32'd1);
        checkOutput("b_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("b_done", 32'(bus.done), 32'd0);

        $display("[TB] illegal lengths");
        w0 = we_count;
        applyStimulus(8'hA5);
        checkOutput("l0_error_cleared", 32'(bus.error), 32'd0);
        applyStimulus(8'h00);
        checkOutput("l0_error", 32'(bus.error), 32'd1);
        applyStimulus(8'hA5);
        applyStimulus(8'h11);
        checkOutput("l17_error", 32'(bus.error), 32'd1);
        idle(2);
        checkOutput("l_no_we", 32'(we_count - w0), 32'd0);
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h7E);
        checkWrite("l_recover_w0", 4'd0, 8'h7E);
        applyStimulus(8'h7E);
        checkOutput("l_recover_done", 32'(bus.done), 32'd1);
        checkOutput("l_recover_error", 32'(bus.error), 32'd0);

        $display("[TB] full depth frame");
        sum = 8'h00;
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i * 3));
            sum = sum + 8'(i * 3);
            checkWrite($sformatf("d16_w%0d", i), 4'(i), 8'(i * 3));
        end
        applyStimulus(8'h68);
        checkOutput("d16_sum_model", 32'(sum), 32'h68);
        checkOutput("d16_done", 32'(bus.done), 32'd1);
        checkOutput("d16_addr_hold", 32'(bus.mem_addr), 32'hF);

        $display("[TB] timeout");
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h10);
        idle(254);
        checkOutput("t_not_yet", 32'(bus.error), 32'd0);
        idle(1);
        checkOutput("t_error", 32'(bus.error), 32'd1);
        checkOutput("t_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        applyStimulus(8'hA5);
        checkOutput("t_hdr_error_clear", 32'(bus.error), 32'd0);
        applyStimulus(8'h01);
        applyStimulus(8'h55);
        checkWrite("t_w0", 4'd0, 8'h55);
        applyStimulus(8'h55);
        checkOutput("t_done", 32'(bus.done), 32'd1);

        $display("[TB] reset mid-DATA");
        applyStimulus(8'hA5);
        applyStimulus(8'h04);
        applyStimulus(8'h01);
        checkWrite("m_w0", 4'd0, 8'h01);
        reset = 1'b1;
        #1;
        checkOutput("m_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("m_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("m_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("m_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("m_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("m_done", 32'(bus.done), 32'd0);
        checkOutput("m_error", 32'(bus.error), 32'd0);
        w0 = we_count;
        idle(2);
        reset = 1'b0;
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        idle(2);
        checkOutput("m_no_we_after", 32'(we_count - w0), 32'd0);
        checkOutput("m_hold_after", 32'(bus.cpu_hold), 32'd1);
        checkOutput("m_done_after", 32'(bus.done), 32'd0);
        checkOutput("m_ready_after", 32'(bus.in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
